// File: rtl/glitch_pulse_gen_pkg.sv
// Shared definitions for the glitch pulse generator: default widths and FSM states.
package glitch_pulse_gen_pkg;

  localparam int unsigned GPG_WIDTH_W = 16;
  localparam int unsigned GPG_COUNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } gpg_state_e;

endpackage

// File: rtl/glitch_pulse_gen_edge_detect.sv
// Rising-edge detector; a level already high when reset releases is not an edge.
module edge_detect (
  input  logic timerclk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic armed;

  always_ff @(posedge timerclk or negedge reset_n) begin
    if (!reset_n) begin
      din_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      din_q <= din;
      if (!din) armed <= 1'b1;
    end
  end

  // armed stays low until din has been observed low at least once
  assign rise = din & ~din_q & armed;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Trigger-driven glitch train: count pulses of width cycles separated by gap cycles.
module glitch_pulse_gen
  import glitch_pulse_gen_pkg::*;
#(
  parameter int unsigned WIDTH_W = GPG_WIDTH_W,
  parameter int unsigned COUNT_W = GPG_COUNT_W
) (
  input  logic               timerclk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               trigger,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic [WIDTH_W-1:0] cfg_gap,
  input  logic [COUNT_W-1:0] cfg_count,
  output logic               glitch_out,
  output logic               busy,
  output logic               done
);

  localparam logic [WIDTH_W-1:0] T_ONE = WIDTH_W'(1);
  localparam logic [COUNT_W-1:0] P_ONE = COUNT_W'(1);

  gpg_state_e         state, state_next;
  logic [WIDTH_W-1:0] width_q, gap_q, tcnt;
  logic [COUNT_W-1:0] pcnt;
  logic               rise, accept, tcnt_last, pcnt_last;

  edge_detect u_edge (
    .timerclk (timerclk),
    .reset_n  (reset_n),
    .din      (trigger),
    .rise     (rise)
  );

  assign accept    = (state == ST_IDLE) && enable && rise;
  assign tcnt_last = (tcnt == T_ONE);
  assign pcnt_last = (pcnt == P_ONE);

  always_ff @(posedge timerclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      glitch_out <= 1'b0;
    end else begin
      state      <= state_next;
      glitch_out <= (state_next == ST_HIGH);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept)
          state_next = (cfg_width == '0 || cfg_count == '0) ? ST_FINISH : ST_HIGH;
      end
      ST_HIGH: begin
        if (!enable)
          state_next = ST_IDLE;
        else if (tcnt_last)
          state_next = pcnt_last ? ST_FINISH : ((gap_q == '0) ? ST_HIGH : ST_GAP);
      end
      ST_GAP: begin
        if (!enable)
          state_next = ST_IDLE;
        else if (tcnt_last)
          state_next = ST_HIGH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // One shared down-counter times both the high and the gap phase.
  always_ff @(posedge timerclk or negedge reset_n) begin
    if (!reset_n) begin
      width_q <= '0;
      gap_q   <= '0;
      tcnt    <= '0;
      pcnt    <= '0;
    end else if (accept) begin
      width_q <= cfg_width;
      gap_q   <= cfg_gap;
      tcnt    <= cfg_width;
      pcnt    <= cfg_count;
    end else if (state_next == ST_IDLE || state_next == ST_FINISH) begin
      tcnt <= '0;
      pcnt <= '0;
    end else begin
      unique case (state)
        ST_HIGH: begin
          if (tcnt_last) begin
            pcnt <= pcnt - P_ONE;
            tcnt <= (gap_q == '0) ? width_q : gap_q;
          end else begin
            tcnt <= tcnt - T_ONE;
          end
        end
        ST_GAP:  tcnt <= tcnt_last ? width_q : (tcnt - T_ONE);
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_FINISH);
  end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Self-checking bench for glitch_pulse_gen: queue-based reference model plus directed trains.
module tb_glitch_pulse_gen;

  localparam int unsigned WW = 16;
  localparam int unsigned CW = 8;

  logic          timerclk = 1'b0;
  logic          reset_n  = 1'b0;
  logic          enable   = 1'b0;
  logic          trigger  = 1'b0;
  logic [WW-1:0] cfg_width = '0;
  logic [WW-1:0] cfg_gap   = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          glitch_out, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 timerclk = ~timerclk;

  glitch_pulse_gen #(.WIDTH_W(WW), .COUNT_W(CW)) dut (
    .timerclk   (timerclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .trigger    (trigger),
    .cfg_width  (cfg_width),
    .cfg_gap    (cfg_gap),
    .cfg_count  (cfg_count),
    .glitch_out (glitch_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an accepted trigger expands into the full list of per-cycle
  // outputs {glitch_out, busy, done}, consumed one entry per clock.
  logic [2:0] exp_q[$];
  logic [2:0] exp_cur    = 3'b000;
  logic       m_prev     = 1'b0;
  logic       m_seen_low = 1'b0;
  logic       m_rise;

  function automatic void build_train(int unsigned w, int unsigned g, int unsigned c);
    if (w == 0 || c == 0) begin
      exp_q.push_back(3'b011);
      return;
    end
    for (int unsigned p = 0; p < c; p++) begin
      for (int unsigned i = 0; i < w; i++) exp_q.push_back(3'b110);
      if (p != c - 1)
        for (int unsigned i = 0; i < g; i++) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b011);
  endfunction

  always @(posedge timerclk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_cur    = 3'b000;
      m_prev     = 1'b0;
      m_seen_low = 1'b0;
    end else begin
      m_rise = trigger && !m_prev && m_seen_low;
      if (exp_cur[1] && !enable) begin
        exp_q.delete();
        exp_cur = 3'b000;
      end else if (!exp_cur[1] && enable && m_rise) begin
        build_train(int'(cfg_width), int'(cfg_gap), int'(cfg_count));
        exp_cur = exp_q.pop_front();
      end else begin
        exp_cur = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
      end
      m_prev     = trigger;
      m_seen_low = m_seen_low | !trigger;
    end
  end

  always @(negedge timerclk)
    check("cycle", 64'({glitch_out, busy, done}), 64'(exp_cur));

  task automatic cyc(input int n);
    repeat (n) @(negedge timerclk);
  endtask

  task automatic fire();
    trigger = 1'b1;
    @(negedge timerclk);
    trigger = 1'b0;
  endtask

  // Counts from the current sample point (k=1 is the cycle after the trigger edge).
  task automatic measure(input int limit, output int hi, output int pulses,
                         output int bz, output int dat, output int dcnt);
    logic prev_g;
    prev_g = 1'b0;
    hi = 0; pulses = 0; bz = 0; dat = -1; dcnt = 0;
    for (int k = 1; k <= limit; k++) begin
      if (glitch_out) hi++;
      if (glitch_out && !prev_g) pulses++;
      prev_g = glitch_out;
      if (busy) bz++;
      if (done) begin
        dcnt++;
        if (dat < 0) dat = k;
      end
      @(negedge timerclk);
    end
  endtask

  task automatic set_cfg(input int unsigned w, input int unsigned g, input int unsigned c);
    cfg_width = WW'(w);
    cfg_gap   = WW'(g);
    cfg_count = CW'(c);
  endtask

  typedef struct {
    int unsigned w, g, c;
    int hi, pulses, bz, dat;
  } vec_t;

  vec_t tbl[7];
  int hi, pulses, bz, dat, dcnt;

  initial begin
    tbl[0] = '{w:3, g:2, c:2, hi:6,  pulses:2, bz:9,  dat:9};
    tbl[1] = '{w:0, g:1, c:5, hi:0,  pulses:0, bz:1,  dat:1};
    tbl[2] = '{w:4, g:0, c:3, hi:12, pulses:1, bz:13, dat:13};
    tbl[3] = '{w:2, g:0, c:0, hi:0,  pulses:0, bz:1,  dat:1};
    tbl[4] = '{w:1, g:1, c:1, hi:1,  pulses:1, bz:2,  dat:2};
    tbl[5] = '{w:1, g:3, c:3, hi:3,  pulses:3, bz:10, dat:10};
    tbl[6] = '{w:5, g:1, c:2, hi:10, pulses:2, bz:12, dat:12};

    cyc(2);
    check("reset_outputs", 64'({glitch_out, busy, done}), 64'(0));
    reset_n = 1'b1;
    enable  = 1'b1;
    cyc(2);

    foreach (tbl[i]) begin
      set_cfg(tbl[i].w, tbl[i].g, tbl[i].c);
      fire();
      measure(60, hi, pulses, bz, dat, dcnt);
      check($sformatf("tbl%0d_high", i),   64'(hi),     64'(tbl[i].hi));
      check($sformatf("tbl%0d_pulses", i), 64'(pulses), 64'(tbl[i].pulses));
      check($sformatf("tbl%0d_busy", i),   64'(bz),     64'(tbl[i].bz));
      check($sformatf("tbl%0d_done_at", i), 64'(dat),   64'(tbl[i].dat));
      check($sformatf("tbl%0d_done_cnt", i), 64'(dcnt), 64'(1));
    end

    // Retrigger and config change during a running train are ignored.
    set_cfg(100, 0, 1);
    fire();
    fork
      measure(150, hi, pulses, bz, dat, dcnt);
      begin
        cyc(10);
        cfg_width = WW'(1);
        fire();
      end
    join
    check("retrig_high", 64'(hi), 64'(100));
    check("retrig_pulses", 64'(pulses), 64'(1));
    check("retrig_done_at", 64'(dat), 64'(101));

    // Enable dropped while high: abort without done, then recover.
    set_cfg(10, 0, 1);
    fire();
    cyc(3);
    enable = 1'b0;
    @(negedge timerclk);
    check("abort_glitch", 64'(glitch_out), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    measure(20, hi, pulses, bz, dat, dcnt);
    check("abort_no_done", 64'(dcnt), 64'(0));
    enable = 1'b1;
    set_cfg(2, 0, 1);
    fire();
    measure(10, hi, pulses, bz, dat, dcnt);
    check("recover_high", 64'(hi), 64'(2));
    check("recover_done_at", 64'(dat), 64'(3));

    // Enable falling together with a trigger edge must not start a train.
    enable  = 1'b0;
    trigger = 1'b1;
    @(negedge timerclk);
    measure(5, hi, pulses, bz, dat, dcnt);
    check("en_fall_trig_busy", 64'(bz), 64'(0));
    trigger = 1'b0;
    enable  = 1'b1;
    cyc(2);

    // Reset mid-gap with trigger held high afterwards.
    set_cfg(2, 5, 2);
    trigger = 1'b1;
    @(negedge timerclk);
    cyc(3);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", 64'({glitch_out, busy, done}), 64'(0));
    @(negedge timerclk);
    reset_n = 1'b1;
    measure(10, hi, pulses, bz, dat, dcnt);
    check("held_trig_no_start", 64'(bz), 64'(0));
    trigger = 1'b0;
    @(negedge timerclk);
    fire();
    measure(20, hi, pulses, bz, dat, dcnt);
    check("post_reset_high", 64'(hi), 64'(4));
    check("post_reset_done_at", 64'(dat), 64'(10));

    // Counter extremes.
    set_cfg(65535, 0, 1);
    fire();
    measure(65600, hi, pulses, bz, dat, dcnt);
    check("max_width_high", 64'(hi), 64'(65535));
    check("max_width_done_at", 64'(dat), 64'(65536));
    set_cfg(1, 0, 255);
    fire();
    measure(300, hi, pulses, bz, dat, dcnt);
    check("max_count_b2b_high", 64'(hi), 64'(255));
    check("max_count_b2b_pulses", 64'(pulses), 64'(1));
    set_cfg(1, 1, 255);
    fire();
    measure(600, hi, pulses, bz, dat, dcnt);
    check("max_count_pulses", 64'(pulses), 64'(255));
    check("max_count_done_at", 64'(dat), 64'(510));

    // Randomized traffic; checked every cycle by the reference model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) trigger = ~trigger;
      enable = ($urandom_range(0, 49) != 0);
      set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3));
      @(negedge timerclk);
    end
    enable  = 1'b1;
    trigger = 1'b0;
    cyc(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
